cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/cpu_phase_counter.sv | 32 +++
 rtl/cpu_sequencer.sv | 104 ++++++++++
 tb/tb_cpu_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode/phase definitions and the control-word layout for the CPU sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  // One bit per control line, ordered as the top-level output list.
  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
    logic halt;
  } ctrl_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Eight-phase instruction cycle counter with a sticky halt freeze at the operand-address phase.
// Latency: phase advances one step per clock; halt takes effect on the edge in phase 4.
// Backpressure: none; free-running until halted, only reset releases a halt.
module cpu_phase_counter
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hlt_op,
  output phase_t phase,
  output logic   halted,
  output logic   wrap
);

  // Step through the phases; a HLT seen in phase 4 locks the counter there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= PH_INST_ADDR;
      halted <= 1'b0;
    end else if (!halted) begin
      if (phase == PH_OP_ADDR && hlt_op) begin
        halted <= 1'b1;
      end else begin
        phase <= phase_t'(phase + 3'd1);
      end
    end
  end

  // Marks the 7->0 step, i.e. one instruction retiring.
  assign wrap = (phase == PH_STORE) && !halted;

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer: decodes phase/opcode/zero into datapath controls and counts retired instructions.
// Latency: controls are combinational from phase and inputs; counter updates on the 7->0 edge.
// Backpressure: none; the instruction cycle is fixed at eight clocks and the counter saturates.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       OPCODE,
  input  logic             ZERO,
  output logic             SEL,
  output logic             RD,
  output logic             LD_IR,
  output logic             INC_PC,
  output logic             LD_PC,
  output logic             DATA_E,
  output logic             LD_AC,
  output logic             WR,
  output logic             HALT,
  output logic [2:0]       PHASE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  opcode_t          op;
  phase_t           phase;
  logic             halted;
  logic             wrap;
  logic             aluop;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] instr_cnt;

  assign op    = opcode_t'(OPCODE);
  assign aluop = is_aluop(op);

  cpu_phase_counter u_phase (
    .clk    (CLK),
    .rst    (RST),
    .hlt_op (op == OP_HLT),
    .phase  (phase),
    .halted (halted),
    .wrap   (wrap)
  );

  // Decode the current phase into control lines; a halted machine drives only HALT.
  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl.halt = 1'b1;
    end else begin
      case (phase)
        PH_INST_ADDR: begin
          ctrl.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          ctrl.inc_pc = (op != OP_HLT);
          ctrl.halt   = (op == OP_HLT);
        end
        PH_OP_FETCH: begin
          ctrl.rd = aluop;
        end
        PH_ALU_OP: begin
          ctrl.rd     = aluop;
          ctrl.inc_pc = (op == OP_SKZ) && ZERO;
          ctrl.ld_pc  = (op == OP_JMP);
          ctrl.data_e = (op == OP_STO);
        end
        PH_STORE: begin
          ctrl.rd     = aluop;
          ctrl.ld_ac  = aluop;
          ctrl.inc_pc = (op == OP_JMP);
          ctrl.ld_pc  = (op == OP_JMP);
          ctrl.data_e = (op == OP_STO);
          ctrl.wr     = (op == OP_STO);
        end
      endcase
    end
  end

  assign {SEL, RD, LD_IR, INC_PC, LD_PC, DATA_E, LD_AC, WR, HALT} = ctrl;
  assign PHASE = phase;

  // Count retired instructions, holding at all-ones once full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_cnt <= '0;
    end else if (wrap && !(&instr_cnt)) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign INSTR_CNT = instr_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a 16-bit and a 4-bit counter instance share stimulus
// and are compared each phase against a rule-level model of the instruction cycle.
module tb_cpu_sequencer;

  logic        CLK    = 1'b0;
  logic        RST    = 1'b1;
  logic [2:0]  OPCODE = 3'd0;
  logic        ZERO   = 1'b0;

  logic        SEL, RD, LD_IR, INC_PC, LD_PC, DATA_E, LD_AC, WR, HALT;
  logic [2:0]  PHASE;
  logic [15:0] INSTR_CNT;

  logic        s4_sel, s4_rd, s4_ld_ir, s4_inc_pc, s4_ld_pc, s4_data_e, s4_ld_ac, s4_wr, s4_halt;
  logic [2:0]  s4_phase;
  logic [3:0]  s4_cnt;

  int tests = 0;
  int fails = 0;

  // Model state: phase number, halted flag, retired counts for both widths.
  int m_phase  = 0;
  bit m_halted = 1'b0;
  int m_cnt16  = 0;
  int m_cnt4   = 0;

  initial forever #5 CLK = ~CLK;

  cpu_sequencer #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO),
    .SEL(SEL), .RD(RD), .LD_IR(LD_IR), .INC_PC(INC_PC), .LD_PC(LD_PC),
    .DATA_E(DATA_E), .LD_AC(LD_AC), .WR(WR), .HALT(HALT), .PHASE(PHASE),
    .INSTR_CNT(INSTR_CNT)
  );

  cpu_sequencer #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO),
    .SEL(s4_sel), .RD(s4_rd), .LD_IR(s4_ld_ir), .INC_PC(s4_inc_pc), .LD_PC(s4_ld_pc),
    .DATA_E(s4_data_e), .LD_AC(s4_ld_ac), .WR(s4_wr), .HALT(s4_halt), .PHASE(s4_phase),
    .INSTR_CNT(s4_cnt)
  );

  wire [11:0] obs  = {SEL, RD, LD_IR, INC_PC, LD_PC, DATA_E, LD_AC, WR, HALT, PHASE};
  wire [11:0] obs4 = {s4_sel, s4_rd, s4_ld_ir, s4_inc_pc, s4_ld_pc, s4_data_e, s4_ld_ac, s4_wr, s4_halt, s4_phase};

  // Expected control word, each output written as its own rule over phase number and opcode.
  function automatic logic [11:0] exp_out(int ph, bit hl, logic [2:0] op, logic z);
    logic sel, rd, ldir, inc, ldpc, de, ldac, wr, hlt;
    logic [2:0] p;
    bit alu;
    p   = 3'(ph);
    alu = (op >= 3'd2) && (op <= 3'd5);
    sel = 1'b0; rd = 1'b0; ldir = 1'b0; inc = 1'b0; ldpc = 1'b0;
    de = 1'b0; ldac = 1'b0; wr = 1'b0; hlt = 1'b0;
    if (hl) begin
      hlt = 1'b1;
    end else begin
      sel  = (ph <= 3);
      rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      ldir = (ph == 2) || (ph == 3);
      inc  = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
      ldpc = (ph >= 6 && op == 3'd7);
      de   = (ph >= 6 && op == 3'd6);
      ldac = (ph == 7 && alu);
      wr   = (ph == 7 && op == 3'd6);
      hlt  = (ph == 4 && op == 3'd0);
    end
    return {sel, rd, ldir, inc, ldpc, de, ldac, wr, hlt, p};
  endfunction

  wire [11:0] exp_v = exp_out(m_phase, m_halted, OPCODE, ZERO);

  task automatic model_reset();
    m_phase  = 0;
    m_halted = 1'b0;
    m_cnt16  = 0;
    m_cnt4   = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge, return at the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (!RST && !m_halted) begin
      if (m_phase == 4 && OPCODE == 3'd0) begin
        m_halted = 1'b1;
      end else begin
        if (m_phase == 7) begin
          m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
          m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
        end
        m_phase = (m_phase + 1) % 8;
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      OPCODE = 3'($urandom);
      ZERO   = 1'($urandom);
      #1;
      tests++;
      if (obs !== exp_v || obs4 !== exp_v || INSTR_CNT !== 16'(m_cnt16) || s4_cnt !== 4'(m_cnt4)) begin
        fails++;
        $display("FAIL reset_hold got=%b/%b cnt=%0d/%0d want=%b cnt=0", obs, obs4, INSTR_CNT, s4_cnt, exp_v);
      end
    end
    RST = 1'b0;
    #1;
    tests++;
    if (obs !== exp_v || INSTR_CNT !== 16'd0) begin
      fails++;
      $display("FAIL reset_release got=%b cnt=%0d want=%b cnt=0", obs, INSTR_CNT, exp_v);
    end
  endtask

  task automatic test_add();
    for (int i = 0; i < 8; i++) begin
      OPCODE = 3'd2;
      ZERO   = 1'($urandom);
      #1;
      tests++;
      if (obs !== exp_v || obs4 !== exp_v || INSTR_CNT !== 16'(m_cnt16) || s4_cnt !== 4'(m_cnt4)) begin
        fails++;
        $display("FAIL add ph=%0d got=%b/%b cnt=%0d/%0d want=%b cnt=%0d", m_phase, obs, obs4, INSTR_CNT, s4_cnt, exp_v, m_cnt16);
      end
      tick();
    end
    #1;
    tests++;
    if (PHASE !== 3'd0 || INSTR_CNT !== 16'd1) begin
      fails++;
      $display("FAIL add_retire phase=%0d cnt=%0d want phase=0 cnt=1", PHASE, INSTR_CNT);
    end
  endtask

  task automatic test_skz();
    for (int zv = 1; zv >= 0; zv--) begin
      int incs = 0;
      for (int i = 0; i < 8; i++) begin
        OPCODE = 3'd1;
        ZERO   = 1'(zv);
        #1;
        tests++;
        if (obs !== exp_v || INSTR_CNT !== 16'(m_cnt16)) begin
          fails++;
          $display("FAIL skz z=%0d ph=%0d got=%b want=%b", zv, m_phase, obs, exp_v);
        end
        incs += int'(INC_PC);
        tick();
      end
      tests++;
      if (incs != (zv == 1 ? 2 : 1)) begin
        fails++;
        $display("FAIL skz_incs z=%0d got=%0d want=%0d", zv, incs, (zv == 1 ? 2 : 1));
      end
    end
  endtask

  task automatic test_sto();
    int wrs = 0;
    for (int i = 0; i < 8; i++) begin
      OPCODE = 3'd6;
      ZERO   = 1'($urandom);
      #1;
      tests++;
      if (obs !== exp_v || INSTR_CNT !== 16'(m_cnt16)) begin
        fails++;
        $display("FAIL sto ph=%0d got=%b want=%b", m_phase, obs, exp_v);
      end
      wrs += int'(WR);
      tick();
    end
    tests++;
    if (wrs != 1) begin
      fails++;
      $display("FAIL sto_wr_pulses got=%0d want=1", wrs);
    end
  endtask

  // Random opcodes per instruction, random ZERO every phase, and junk opcodes in phases 0-3.
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [2:0] ins = 3'($urandom_range(7, 1));
      for (int i = 0; i < 8; i++) begin
        OPCODE = (i < 4) ? 3'($urandom) : ins;
        ZERO   = 1'($urandom);
        #1;
        tests++;
        if (obs !== exp_v || obs4 !== exp_v || INSTR_CNT !== 16'(m_cnt16) || s4_cnt !== 4'(m_cnt4)) begin
          fails++;
          $display("FAIL random op=%0d ph=%0d got=%b/%b cnt=%0d/%0d want=%b cnt=%0d/%0d",
                   OPCODE, m_phase, obs, obs4, INSTR_CNT, s4_cnt, exp_v, m_cnt16, m_cnt4);
        end
        tick();
      end
    end
  endtask

  task automatic test_jmp_reset();
    for (int i = 0; i < 7; i++) begin
      OPCODE = 3'd7;
      ZERO   = 1'($urandom);
      #1;
      tests++;
      if (obs !== exp_v || INSTR_CNT !== 16'(m_cnt16)) begin
        fails++;
        $display("FAIL jmp ph=%0d got=%b want=%b", m_phase, obs, exp_v);
      end
      if (i < 6) tick();
    end
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    tests++;
    if (obs !== exp_v || obs4 !== exp_v || INSTR_CNT !== 16'd0 || s4_cnt !== 4'd0) begin
      fails++;
      $display("FAIL jmp_async_reset got=%b cnt=%0d/%0d want=%b cnt=0", obs, INSTR_CNT, s4_cnt, exp_v);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_halt();
    for (int i = 0; i < 8; i++) begin
      OPCODE = 3'd2;
      ZERO   = 1'($urandom);
      #1;
      tests++;
      if (obs !== exp_v || INSTR_CNT !== 16'(m_cnt16)) begin
        fails++;
        $display("FAIL halt_pre ph=%0d got=%b want=%b", m_phase, obs, exp_v);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      OPCODE = 3'($urandom);
      tick();
    end
    OPCODE = 3'd0;
    #1;
    tests++;
    if (obs !== exp_v || HALT !== 1'b1 || INC_PC !== 1'b0) begin
      fails++;
      $display("FAIL halt_enter got=%b halt=%b inc_pc=%b want=%b", obs, HALT, INC_PC, exp_v);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      OPCODE = 3'($urandom);
      ZERO   = 1'($urandom);
      #1;
      tests++;
      if (obs !== exp_v || obs4 !== exp_v || INSTR_CNT !== 16'(m_cnt16)) begin
        fails++;
        $display("FAIL halted i=%0d got=%b cnt=%0d want=%b cnt=%0d", i, obs, INSTR_CNT, exp_v, m_cnt16);
      end
      tick();
    end
    tests++;
    if (PHASE !== 3'd4 || INSTR_CNT !== 16'd1) begin
      fails++;
      $display("FAIL halt_frozen phase=%0d cnt=%0d want phase=4 cnt=1", PHASE, INSTR_CNT);
    end
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    tests++;
    if (obs !== exp_v || HALT !== 1'b0 || INSTR_CNT !== 16'd0) begin
      fails++;
      $display("FAIL halt_reset got=%b halt=%b cnt=%0d want=%b", obs, HALT, INSTR_CNT, exp_v);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) begin
        OPCODE = 3'd2;
        ZERO   = 1'($urandom);
        #1;
        tests++;
        if (obs4 !== exp_v || s4_cnt !== 4'(m_cnt4) || INSTR_CNT !== 16'(m_cnt16)) begin
          fails++;
          $display("FAIL sat n=%0d ph=%0d cnt=%0d/%0d want=%0d/%0d", n, m_phase, INSTR_CNT, s4_cnt, m_cnt16, m_cnt4);
        end
        tick();
      end
    end
    tests++;
    if (s4_cnt !== 4'd15 || INSTR_CNT !== 16'd20) begin
      fails++;
      $display("FAIL sat_final cnt4=%0d cnt16=%0d want 15 and 20", s4_cnt, INSTR_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_skz();
    test_sto();
    test_random();
    test_jmp_reset();
    test_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
